// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the RAM bus sequencer.
// Optional misalignment trap state is enabled by MEM_MISALIGN_TRAP_EN.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
`ifdef MEM_MISALIGN_TRAP_EN
        ST_FAULT = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam int unsigned CNT_W = 4;

    localparam logic ACK_PULSE   = 1'b1;
    localparam logic FAULT_PULSE = 1'b1;

    // Number of byte-offset bits inside one bus word.
    function automatic int unsigned lane_bits(input int unsigned xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

    // A dword access on a 32-bit bus collapses to a word access.
    function automatic logic [1:0] eff_size(input int unsigned xlen, input logic [1:0] size);
        return (xlen == 32 && size == SIZE_DWORD) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Lane extract with sign/zero extension, and lane insert for read-modify-write merges.
module lane_align
    import cpu_bus_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0]                 word,
    input  logic [lane_bits(XLEN)-1:0]      offset,
    input  logic [1:0]                      size,
    input  logic                            sign_ext,
    input  logic [XLEN-1:0]                 ins_data,
    output logic [XLEN-1:0]                 ext_data_c,
    output logic [XLEN-1:0]                 merge_data_c
);

    localparam int unsigned LB   = lane_bits(XLEN);
    localparam int unsigned SH_W = LB + 3;

    logic [1:0]      sz;
    logic [LB-1:0]   sz_mask;
    logic [LB-1:0]   off_al;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign_bit;

    // Offset bits below the access size are dropped, so lanes are always naturally aligned.
    always_comb begin
        sz       = eff_size(XLEN, size);
        sz_mask  = LB'((32'd1 << sz) - 32'd1);
        off_al   = offset & ~sz_mask;
        shamt    = {off_al, 3'b000};
        shifted  = word >> shamt;
        mask     = '1;
        sign_bit = shifted[XLEN-1];
        case (sz)
            SIZE_BYTE: begin
                mask     = XLEN'(8'hFF);
                sign_bit = shifted[7];
            end
            SIZE_HALF: begin
                mask     = XLEN'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SIZE_WORD: begin
                mask     = XLEN'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                mask     = '1;
                sign_bit = shifted[XLEN-1];
            end
        endcase
        ext_data_c = shifted & mask;
        if (sign_ext && sign_bit) begin
            ext_data_c = ext_data_c | ~mask;
        end
        merge_data_c = (word & ~(mask << shamt)) | ((ins_data & mask) << shamt);
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Serialises instruction fetches and load/stores onto the single RAM bus.
// MEM_MISALIGN_TRAP_EN adds a mem_fault port and traps misaligned data accesses.
module mem_bus_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ack,
    output logic [INSTR_W-1:0] fetch_instr,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [1:0]         mem_size,
    input  logic               mem_signed,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [XLEN-1:0]    mem_wdata,
    output logic               mem_ack,
    output logic [XLEN-1:0]    mem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               mem_fault,
`endif
    output logic               busy,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic [XLEN-1:0]    bus_wdata,
    output logic               bus_wdata_oe,
    input  logic [XLEN-1:0]    bus_rdata,
    output logic               ram_cs,
    output logic               ram_we,
    output logic               ram_oe
);

    localparam int unsigned    LB        = lane_bits(XLEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [1:0]     FULL_SIZE = (XLEN == 64) ? SIZE_DWORD : SIZE_WORD;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_fetch_q, is_fetch_d;
    logic               rmw_q, rmw_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;

    logic               fetch_ack_q, fetch_ack_d;
    logic [INSTR_W-1:0] fetch_instr_q, fetch_instr_d;
    logic               mem_ack_q, mem_ack_d;
    logic [XLEN-1:0]    mem_rdata_q, mem_rdata_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]    bus_wdata_q, bus_wdata_d;
    logic               ram_cs_q, ram_cs_d;
    logic               ram_we_q, ram_we_d;
    logic               ram_oe_q, ram_oe_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               mem_fault_q, mem_fault_d;
    logic               misaligned;
`endif

    logic [XLEN-1:0]    ext_data;
    logic [XLEN-1:0]    merge_data;

    lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .word         (bus_rdata),
        .offset       (addr_q[LB-1:0]),
        .size         (size_q),
        .sign_ext     (sgn_q),
        .ins_data     (wdata_q),
        .ext_data_c   (ext_data),
        .merge_data_c (merge_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    // Any address bit below the access size, or a dword on a 32-bit bus, traps.
    always_comb begin
        misaligned = ((mem_addr[LB-1:0] & LB'((32'd1 << mem_size) - 32'd1)) != '0)
                   || (XLEN == 32 && mem_size == SIZE_DWORD);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            is_fetch_q    <= 1'b0;
            rmw_q         <= 1'b0;
            size_q        <= '0;
            sgn_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            fetch_ack_q   <= 1'b0;
            fetch_instr_q <= '0;
            mem_ack_q     <= 1'b0;
            mem_rdata_q   <= '0;
            busy_q        <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            ram_cs_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_oe_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_fault_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_fetch_q    <= is_fetch_d;
            rmw_q         <= rmw_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            fetch_ack_q   <= fetch_ack_d;
            fetch_instr_q <= fetch_instr_d;
            mem_ack_q     <= mem_ack_d;
            mem_rdata_q   <= mem_rdata_d;
            busy_q        <= busy_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            ram_cs_q      <= ram_cs_d;
            ram_we_q      <= ram_we_d;
            ram_oe_q      <= ram_oe_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_fault_q   <= mem_fault_d;
`endif
        end
    end

    // Next state; outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_fetch_d    = is_fetch_q;
        rmw_d         = rmw_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        fetch_ack_d   = 1'b0;
        fetch_instr_d = fetch_instr_q;
        mem_ack_d     = 1'b0;
        mem_rdata_d   = mem_rdata_q;
        bus_wdata_d   = bus_wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mem_fault_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    is_fetch_d = 1'b0;
                    rmw_d      = 1'b0;
                    size_d     = mem_size;
                    sgn_d      = mem_signed;
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    cnt_d      = CNT_LOAD;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d     = ST_FAULT;
                        mem_ack_d   = ACK_PULSE;
                        mem_fault_d = FAULT_PULSE;
                        mem_rdata_d = '0;
                    end else
`endif
                    if (!mem_we) begin
                        state_d = ST_RD;
                    end else if (eff_size(XLEN, mem_size) == FULL_SIZE) begin
                        state_d     = ST_WR;
                        bus_wdata_d = mem_wdata;
                    end else begin
                        state_d = ST_RD;
                        rmw_d   = 1'b1;
                    end
                end else if (fetch_req) begin
                    is_fetch_d = 1'b1;
                    rmw_d      = 1'b0;
                    size_d     = SIZE_WORD;
                    sgn_d      = 1'b0;
                    addr_d     = fetch_addr;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rmw_q) begin
                    // The merge goes straight to WR so nothing can slip in between.
                    state_d     = ST_WR;
                    cnt_d       = CNT_LOAD;
                    bus_wdata_d = merge_data;
                end else begin
                    state_d = ST_DONE;
                    if (is_fetch_q) begin
                        fetch_ack_d   = ACK_PULSE;
                        fetch_instr_d = ext_data[INSTR_W-1:0];
                    end else begin
                        mem_ack_d   = ACK_PULSE;
                        mem_rdata_d = ext_data;
                    end
                end
            end
            ST_WR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d   = ST_DONE;
                    mem_ack_d = ACK_PULSE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            ST_FAULT: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ram_cs_d   = (state_d == ST_RD) || (state_d == ST_WR);
        ram_oe_d   = (state_d == ST_RD);
        ram_we_d   = (state_d == ST_WR);
        busy_d     = (state_d != ST_IDLE);
        bus_addr_d = ram_cs_d ? {addr_d[ADDR_W-1:LB], LB'(0)} : '0;
        if (!ram_we_d) begin
            bus_wdata_d = '0;
        end
    end

    assign fetch_ack    = fetch_ack_q;
    assign fetch_instr  = fetch_instr_q;
    assign mem_ack      = mem_ack_q;
    assign mem_rdata    = mem_rdata_q;
    assign busy         = busy_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wdata_oe = ram_we_q;
    assign ram_cs       = ram_cs_q;
    assign ram_we       = ram_we_q;
    assign ram_oe       = ram_oe_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_fault    = mem_fault_q;
`endif

endmodule
